// File: rtl/ex_muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers (EX stage).
// Shift-add multiply and restoring divide, one bit per cycle, then one
// sign-fix cycle that writes HI/LO.
module ex_muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [5:0]       funcode,
  input  logic [WIDTH-1:0] ReadData1,
  input  logic [WIDTH-1:0] ReadData2,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data
);

  localparam logic [5:0] F_MFHI = 6'h10;
  localparam logic [5:0] F_MTHI = 6'h11;
  localparam logic [5:0] F_MFLO = 6'h12;
  localparam logic [5:0] F_MTLO = 6'h13;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc;    // mult: {partial, multiplier}; div: {-, dividend/quotient}
  logic [WIDTH-1:0]     rem;    // divide partial remainder
  logic [WIDTH-1:0]     opnd;   // multiplicand or divisor magnitude
  logic                 op_div;
  logic                 neg_p;  // product / quotient negate
  logic                 neg_r;  // remainder negate

  logic                 is_md;
  logic                 is_signed;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift;
  logic                 div_borrow;
  logic [WIDTH-1:0]     div_rem_nxt;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  // Operand decode and one-bit-per-cycle datapath arithmetic.
  always_comb begin
    is_md       = (funcode[5:2] == 4'b0110);
    is_signed   = ~funcode[0];
    abs_a       = (is_signed && ReadData1[WIDTH-1]) ? -ReadData1 : ReadData1;
    abs_b       = (is_signed && ReadData2[WIDTH-1]) ? -ReadData2 : ReadData2;
    mul_sum     = acc[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd})
                         : {1'b0, acc[2*WIDTH-1:WIDTH]};
    div_shift   = {rem, acc[WIDTH-1]};
    div_borrow  = (div_shift < {1'b0, opnd});
    div_rem_nxt = div_borrow ? div_shift[WIDTH-1:0] : (div_shift[WIDTH-1:0] - opnd);
    prod_fix    = neg_p ? -acc : acc;
    quo_fix     = neg_p ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix     = neg_r ? -rem : rem;
  end

  // Next-state logic; abort wins over everything else.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start && is_md) state_nxt = CALC;
        CALC:    if (cnt == CNT_LAST) state_nxt = FIX;
        FIX:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register; busy is registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  // Working registers and HI/LO updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      rem    <= '0;
      opnd   <= '0;
      op_div <= 1'b0;
      neg_p  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else if (!abort) begin
      case (state)
        IDLE: begin
          if (start && is_md) begin
            cnt    <= '0;
            rem    <= '0;
            op_div <= funcode[1];
            acc    <= {{WIDTH{1'b0}}, funcode[1] ? abs_a : abs_b};
            opnd   <= funcode[1] ? abs_b : abs_a;
            neg_r  <= is_signed && ReadData1[WIDTH-1];
            // No quotient negation on divide by zero so lo stays all ones.
            neg_p  <= is_signed && (ReadData1[WIDTH-1] ^ ReadData2[WIDTH-1]) &&
                      !(funcode[1] && (ReadData2 == '0));
          end else if (start && funcode == F_MTHI) begin
            hi <= ReadData1;
          end else if (start && funcode == F_MTLO) begin
            lo <= ReadData1;
          end
        end
        CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (op_div) begin
            rem <= div_rem_nxt;
            acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], ~div_borrow};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
        end
        FIX: begin
          if (op_div) begin
            lo <= quo_fix;
            hi <= rem_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Combinational mfhi/mflo read port.
  always_comb begin
    rd_data = '0;
    if (funcode == F_MFHI) rd_data = hi;
    else if (funcode == F_MFLO) rd_data = lo;
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [5:0]  funcode;
  logic [31:0] ReadData1, ReadData2;
  logic        busy;
  logic [31:0] hi, lo, rd_data;

  int tests = 0;
  int fails = 0;
  int n;

  ex_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .funcode(funcode),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .busy(busy), .hi(hi), .lo(lo), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one op for a single edge.
  task automatic issue(input logic [5:0] fc, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; funcode = fc; ReadData1 = a; ReadData2 = b;
    step();
    start = 1'b0; funcode = 6'h00;
  endtask

  // Count sampled busy cycles until it drops, bounded.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (busy && cycles < 200) begin
      cycles++;
      step();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; funcode = 6'h00;
    ReadData1 = '0; ReadData2 = '0;
    #12;
    check("reset busy", {31'b0, busy}, 32'h0);
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    rst = 1'b0;
    step();

    // multu max x max, with latency
    issue(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n);
    check("multu cycles", n, 32'd33);
    check("multu hi", hi, 32'hFFFF_FFFE);
    check("multu lo", lo, 32'h0000_0001);

    // mult -7 x 3, then mfhi/mflo read port
    issue(6'h18, 32'hFFFF_FFF9, 32'h3);
    wait_done(n);
    check("mult hi", hi, 32'hFFFF_FFFF);
    check("mult lo", lo, 32'hFFFF_FFEB);
    funcode = 6'h10; #1;
    check("mfhi rd_data", rd_data, 32'hFFFF_FFFF);
    funcode = 6'h12; #1;
    check("mflo rd_data", rd_data, 32'hFFFF_FFEB);
    funcode = 6'h18; #1;
    check("rd_data other", rd_data, 32'h0);
    funcode = 6'h00;

    // mult -2 x -3 (both negative)
    issue(6'h18, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    wait_done(n);
    check("mult nn hi", hi, 32'h0);
    check("mult nn lo", lo, 32'h6);

    // div -7 / 2
    issue(6'h1A, 32'hFFFF_FFF9, 32'h2);
    wait_done(n);
    check("div cycles", n, 32'd33);
    check("div lo", lo, 32'hFFFF_FFFD);
    check("div hi", hi, 32'hFFFF_FFFF);

    // divu 100 / 0
    issue(6'h1B, 32'd100, 32'h0);
    wait_done(n);
    check("divu0 cycles", n, 32'd33);
    check("divu0 lo", lo, 32'hFFFF_FFFF);
    check("divu0 hi", hi, 32'd100);

    // divu all-ones / 0
    issue(6'h1B, 32'hFFFF_FFFF, 32'h0);
    wait_done(n);
    check("divu0 max lo", lo, 32'hFFFF_FFFF);
    check("divu0 max hi", hi, 32'hFFFF_FFFF);

    // signed overflow divide
    issue(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n);
    check("div ovf lo", lo, 32'h8000_0000);
    check("div ovf hi", hi, 32'h0);

    // abort in CALC cycle 10; mthi in the abort cycle is ignored
    issue(6'h18, 32'd5, 32'd6);
    for (int i = 0; i < 10; i++) step();
    check("abort busy before", {31'b0, busy}, 32'h1);
    abort = 1'b1; start = 1'b1; funcode = 6'h11; ReadData1 = 32'hDEAD_BEEF;
    step();
    abort = 1'b0; start = 1'b0; funcode = 6'h00;
    check("abort busy", {31'b0, busy}, 32'h0);
    check("abort hi", hi, 32'h0);
    check("abort lo", lo, 32'h8000_0000);
    step();
    check("abort busy stays", {31'b0, busy}, 32'h0);

    // mthi then mtlo back to back
    issue(6'h11, 32'h1234, 32'h0);
    check("mthi busy", {31'b0, busy}, 32'h0);
    issue(6'h13, 32'h5678, 32'h0);
    check("mtlo busy", {31'b0, busy}, 32'h0);
    check("mthi hi", hi, 32'h1234);
    check("mtlo lo", lo, 32'h5678);

    // mtlo while busy must not touch lo
    issue(6'h19, 32'd2, 32'd3);
    step();
    issue(6'h13, 32'hAAAA, 32'h0);
    wait_done(n);
    check("mtlo busy lo", lo, 32'd6);
    check("mtlo busy hi", hi, 32'd0);

    // async reset mid-CALC
    issue(6'h11, 32'h11, 32'h0);
    issue(6'h18, 32'd5, 32'd6);
    for (int i = 0; i < 5; i++) step();
    #2 rst = 1'b1;
    #1;
    check("arst busy", {31'b0, busy}, 32'h0);
    check("arst hi", hi, 32'h0);
    check("arst lo", lo, 32'h0);
    rst = 1'b0;
    step();

    // divu 9 / 4 after reset
    issue(6'h1B, 32'd9, 32'd4);
    wait_done(n);
    check("post rst cycles", n, 32'd33);
    check("post rst lo", lo, 32'd2);
    check("post rst hi", hi, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
